// File: rtl/mem_axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_axi_pkg : shared types and constants for the MEM-stage AXI-lite   |
// | initiator.                                      Rev 1.0              |
// +----------------------------------------------------------------------+
package mem_axi_pkg;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd3;
  localparam logic [2:0] SZ_HU = 3'd4;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // Requests that must be answered with an error and never reach the bus.
  function automatic logic req_illegal(input logic wen, input logic [2:0] size,
                                       input logic [1:0] off, input logic align_chk);
    logic bad_size;
    logic misal;
    bad_size = (size > SZ_HU) || (wen && (size > SZ_W));
    case (size)
      SZ_H, SZ_HU: misal = off[0];
      SZ_W:        misal = |off;
      default:     misal = 1'b0;
    endcase
    return bad_size || (align_chk && misal);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_lane_align : store byte-lane placement and load extraction/extend.|
// |                                                 Rev 1.0              |
// +----------------------------------------------------------------------+
module mem_lane_align
  import mem_axi_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_data_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_ext_o
);

  logic [4:0]  shamt;
  logic [31:0] sh;

  assign shamt   = {off_i, 3'b000};
  assign wdata_o = st_data_i << shamt;
  assign sh      = ld_data_i >> shamt;

  // Strobe shifts stay 4 bits wide, so unaligned halves lose lanes above 3.
  always_comb begin
    wstrb_o = 4'b1111;
    case (size_i)
      SZ_B:    wstrb_o = 4'b0001 << off_i;
      SZ_H:    wstrb_o = 4'b0011 << off_i;
      default: wstrb_o = 4'b1111;
    endcase
  end

  always_comb begin
    ld_ext_o = sh;
    case (size_i)
      SZ_B:    ld_ext_o = {{24{sh[7]}}, sh[7:0]};
      SZ_H:    ld_ext_o = {{16{sh[15]}}, sh[15:0]};
      SZ_BU:   ld_ext_o = {24'd0, sh[7:0]};
      SZ_HU:   ld_ext_o = {16'd0, sh[15:0]};
      default: ld_ext_o = sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_axi_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_axi_initiator : single-outstanding AXI-lite load/store initiator  |
// | for the MEM stage.                              Rev 1.0              |
// +----------------------------------------------------------------------+
module mem_axi_initiator
  import mem_axi_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_size_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic        rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  state_e      state_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] awaddr_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic        accept;
  logic        illegal;
  logic [2:0]  la_size;
  logic [1:0]  la_off;
  logic [3:0]  la_wstrb;
  logic [31:0] la_wdata;
  logic [31:0] la_ld;
  logic        aw_hs;
  logic        w_hs;
  logic [31:0] word_addr;

  assign accept    = req_valid_i && req_ready_q;
  assign illegal   = req_illegal(req_wen_i, req_size_i, req_addr_i[1:0], ALIGN_CHECK);
  assign word_addr = {req_addr_i[31:2], 2'b00};
  assign aw_hs     = awvalid_q && awready_i;
  assign w_hs      = wvalid_q && wready_i;

  // Stores are aligned from the live request at accept; loads use the latched size/offset.
  assign la_size = (state_q == ST_IDLE) ? req_size_i : size_q;
  assign la_off  = (state_q == ST_IDLE) ? req_addr_i[1:0] : off_q;

  mem_lane_align u_lane_align (
    .size_i    (la_size),
    .off_i     (la_off),
    .st_data_i (req_wdata_i),
    .ld_data_i (rdata_i),
    .wstrb_o   (la_wstrb),
    .wdata_o   (la_wdata),
    .ld_ext_o  (la_ld)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      size_q       <= 3'd0;
      off_q        <= 2'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= RESP_OK;
      araddr_q     <= 32'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= 32'd0;
      awvalid_q    <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            size_q      <= req_size_i;
            off_q       <= req_addr_i[1:0];
            if (illegal) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= RESP_ERR;
              resp_rdata_q <= 32'd0;
              state_q      <= ST_RESP;
            end else if (req_wen_i) begin
              awaddr_q  <= word_addr;
              awvalid_q <= 1'b1;
              wdata_q   <= la_wdata;
              wstrb_q   <= la_wstrb;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_AW_W;
            end else begin
              araddr_q  <= word_addr;
              arvalid_q <= 1'b1;
              state_q   <= ST_AR;
            end
          end
        end

        ST_AR: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end

        ST_R: begin
          if (rvalid_i) begin
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= rresp_i;
            resp_rdata_q <= rresp_i ? 32'd0 : la_ld;
            state_q      <= ST_RESP;
          end
        end

        ST_AW_W: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= ST_B;
          end
        end

        ST_B: begin
          if (bvalid_i) begin
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= bresp_i;
            resp_rdata_q <= 32'd0;
            state_q      <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign araddr_o     = araddr_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;
  assign awaddr_o     = awaddr_q;
  assign awvalid_o    = awvalid_q;
  assign wdata_o      = wdata_q;
  assign wstrb_o      = wstrb_q;
  assign wvalid_o     = wvalid_q;
  assign bready_o     = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_axi_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_axi_initiator : directed bench with a small AXI-lite responder.|
// |                                                 Rev 1.0              |
// +----------------------------------------------------------------------+
module tb_mem_axi_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_wen_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [2:0]  req_size_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic [31:0] araddr_o, rdata_i, awaddr_o, wdata_o;
  logic        arvalid_o, arready_i, rresp_i, rvalid_i, rready_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i;
  logic [3:0]  wstrb_o;
  logic        bresp_i, bvalid_i, bready_o;

  always #5 clk = ~clk;

  mem_axi_initiator #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // responder configuration
  logic [31:0] s_rdata;
  logic        s_rresp, s_bresp;
  int          s_ar_dly, s_aw_dly, s_w_dly;
  // observations from the last transaction
  logic [31:0] o_araddr, o_awaddr, o_wdata, o_rdata;
  logic [3:0]  o_wstrb;
  logic        o_err, ar_seen, done;
  int          o_lat, ar_hs, aw_hs, w_hs, b_hs;

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] size);
    int k;
    k = 0;
    while (!req_ready_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("req_ready_before_issue", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_size_i  = size;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  // Acts as the subordinate each cycle until the response is taken.
  task automatic serve(input int budget);
    int ar_c, aw_c, w_c;
    ar_c = 0; aw_c = 0; w_c = 0;
    ar_seen = 1'b0; done = 1'b0; o_lat = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    o_araddr = '0; o_awaddr = '0; o_wdata = '0; o_wstrb = '0; o_rdata = '0; o_err = 1'b0;
    for (int i = 1; i <= budget && !done; i++) begin
      if (arvalid_o) begin
        ar_seen = 1'b1; o_araddr = araddr_o;
        arready_i = (ar_c >= s_ar_dly); ar_c++;
        if (arready_i) ar_hs++;
      end else arready_i = 1'b0;
      rvalid_i = rready_o; rdata_i = s_rdata; rresp_i = s_rresp;
      if (awvalid_o) begin
        o_awaddr = awaddr_o;
        awready_i = (aw_c >= s_aw_dly); aw_c++;
        if (awready_i) aw_hs++;
      end else awready_i = 1'b0;
      if (wvalid_o) begin
        o_wdata = wdata_o; o_wstrb = wstrb_o;
        wready_i = (w_c >= s_w_dly); w_c++;
        if (wready_i) w_hs++;
      end else wready_i = 1'b0;
      bvalid_i = bready_o; bresp_i = s_bresp;
      if (bready_o) b_hs++;
      if (resp_valid_o) begin
        done = 1'b1; o_lat = i; o_rdata = resp_rdata_o; o_err = resp_err_o;
        resp_ready_i = 1'b1;
      end
      @(posedge clk); #1;
      resp_ready_i = 1'b0;
    end
    arready_i = 1'b0; rvalid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
    check_eq("txn_completed", 32'(done), 32'd1);
  endtask

  task automatic cfg(input logic [31:0] rd, input logic rr, input logic br,
                     input int ard, input int awd, input int wd);
    s_rdata = rd; s_rresp = rr; s_bresp = br;
    s_ar_dly = ard; s_aw_dly = awd; s_w_dly = wd;
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] exp_data, input logic exp_err);
    issue(1'b0, addr, 32'd0, size);
    serve(40);
    check_eq({tag, "_rdata"}, o_rdata, exp_data);
    check_eq({tag, "_err"}, 32'(o_err), 32'(exp_err));
  endtask

  task automatic store_rt(input string tag, input int awd, input int wd, input int exp_lat);
    cfg(32'd0, 1'b0, 1'b0, 0, awd, wd);
    issue(1'b1, 32'h8000_0008, 32'hCAFE_F00D, 3'd2);
    serve(40);
    check_eq({tag, "_aw_once"}, 32'(aw_hs), 32'd1);
    check_eq({tag, "_w_once"}, 32'(w_hs), 32'd1);
    check_eq({tag, "_b_once"}, 32'(b_hs), 32'd1);
    check_eq({tag, "_wdata"}, o_wdata, 32'hCAFE_F00D);
    check_eq({tag, "_lat"}, 32'(o_lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid_i = 0; req_wen_i = 0; req_addr_i = 0; req_wdata_i = 0; req_size_i = 0;
    resp_ready_i = 0; arready_i = 0; rdata_i = 0; rresp_i = 0; rvalid_i = 0;
    awready_i = 0; wready_i = 0; bresp_i = 0; bvalid_i = 0;
    cfg(32'd0, 1'b0, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_arvalid", 32'(arvalid_o), 32'd0);
    check_eq("rst_awvalid", 32'(awvalid_o), 32'd0);
    check_eq("rst_wvalid", 32'(wvalid_o), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready_o), 32'd0);
    check_eq("rst_araddr", araddr_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_req_ready", 32'(req_ready_o), 32'd1);

    // word load, zero-wait responder
    cfg(32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0, 0);
    load("lw", 32'h8000_0004, 3'd2, 32'hDEAD_BEEF, 1'b0);
    check_eq("lw_araddr", o_araddr, 32'h8000_0004);
    check_eq("lw_latency", 32'(o_lat), 32'd3);

    cfg(32'h80AA_BBCC, 1'b0, 1'b0, 0, 0, 0);
    load("lb", 32'h8000_0003, 3'd0, 32'hFFFF_FF80, 1'b0);
    check_eq("lb_araddr", o_araddr, 32'h8000_0000);
    load("lbu", 32'h8000_0003, 3'd3, 32'h0000_0080, 1'b0);
    load("lhu", 32'h8000_0002, 3'd4, 32'h0000_80AA, 1'b0);
    load("lh", 32'h8000_0002, 3'd1, 32'hFFFF_80AA, 1'b0);
    load("lb0", 32'h8000_0000, 3'd0, 32'hFFFF_FFCC, 1'b0);
    cfg(32'h80AA_BBCC, 1'b0, 1'b0, 2, 0, 0);
    load("lw_ardly", 32'h8000_0010, 3'd2, 32'h80AA_BBCC, 1'b0);
    check_eq("lw_ardly_latency", 32'(o_lat), 32'd5);

    // half store into upper lanes
    cfg(32'd0, 1'b0, 1'b0, 0, 0, 0);
    issue(1'b1, 32'h8000_0002, 32'h0000_1234, 3'd1);
    serve(40);
    check_eq("sh_awaddr", o_awaddr, 32'h8000_0000);
    check_eq("sh_wstrb", 32'(o_wstrb), 32'h0000_000C);
    check_eq("sh_wdata", o_wdata, 32'h1234_0000);
    check_eq("sh_err", 32'(o_err), 32'd0);
    check_eq("sh_rdata", o_rdata, 32'd0);

    issue(1'b1, 32'h8000_0001, 32'h0000_00AB, 3'd0);
    serve(40);
    check_eq("sb_wstrb", 32'(o_wstrb), 32'h0000_0002);
    check_eq("sb_wdata", o_wdata, 32'h0000_AB00);

    store_rt("aw_first", 0, 3, 6);
    store_rt("w_first", 3, 0, 6);
    store_rt("aw_w_same", 0, 0, 3);

    // error paths
    cfg(32'h1111_1111, 1'b0, 1'b0, 0, 0, 0);
    load("lw_misal", 32'h8000_0001, 3'd2, 32'd0, 1'b1);
    check_eq("lw_misal_no_ar", 32'(ar_seen), 32'd0);
    load("lhu_misal", 32'h8000_0003, 3'd4, 32'd0, 1'b1);
    load("bad_size", 32'h8000_0000, 3'd5, 32'd0, 1'b1);
    check_eq("bad_size_no_ar", 32'(ar_seen), 32'd0);
    cfg(32'h1111_1111, 1'b1, 1'b0, 0, 0, 0);
    load("rresp_err", 32'h8000_0000, 3'd2, 32'd0, 1'b1);

    cfg(32'd0, 1'b0, 1'b1, 0, 0, 0);
    issue(1'b1, 32'h8000_0004, 32'h5555_AAAA, 3'd2);
    serve(40);
    check_eq("bresp_err", 32'(o_err), 32'd1);
    check_eq("bresp_rdata", o_rdata, 32'd0);

    cfg(32'd0, 1'b0, 1'b0, 0, 0, 0);
    issue(1'b1, 32'h8000_0000, 32'h0, 3'd4);
    serve(40);
    check_eq("store_hu_err", 32'(o_err), 32'd1);
    check_eq("store_hu_no_aw", o_awaddr, 32'd0);

    // reset while AR is stalled
    issue(1'b0, 32'h8000_0020, 32'd0, 3'd2);
    repeat (5) begin
      arready_i = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("ar_held", 32'(arvalid_o), 32'd1);
    check_eq("ar_held_addr", araddr_o, 32'h8000_0020);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_arvalid", 32'(arvalid_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_req_ready", 32'(req_ready_o), 32'd1);
    check_eq("midrst_arvalid2", 32'(arvalid_o), 32'd0);
    cfg(32'h0123_4567, 1'b0, 1'b0, 0, 0, 0);
    load("after_rst", 32'h8000_0008, 3'd2, 32'h0123_4567, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
